// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU ops plus iterative shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CONTROL_WIDTH-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST = SW'(W - 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     state_q;
  logic [3:0]     op_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, res_q, fast_d, slow_d;
  logic [SW-1:0]  cnt_q;
  logic           neg_q, eq_q, zero_q;

  logic [3:0]   op_in;
  logic [SW-1:0] sh;
  logic         div0, ovf, iterate;
  logic [W-1:0] a_abs, b_abs, quo;
  logic [W:0]   sum, rem_sh, diff;

  assign op_in     = 4'(ALUControl);
  assign sh        = SrcB[SW-1:0];
  assign div0      = (op_in >= 4'hD) && (SrcB == '0);
  assign ovf       = (op_in == 4'hD) && (SrcA == MIN_NEG) && (&SrcB);
  assign iterate   = (op_in >= 4'hB) && !div0 && !ovf;
  assign a_abs     = SrcA[W-1] ? -SrcA : SrcA;
  assign b_abs     = SrcB[W-1] ? -SrcB : SrcB;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign ALUResult = res_q;
  assign Zero      = zero_q;

  always_comb begin
    fast_d = '0;
    case (op_in)
      4'h0: fast_d = SrcA + SrcB;
      4'h1: fast_d = SrcA - SrcB;
      4'h2: fast_d = SrcA & SrcB;
      4'h3: fast_d = SrcA | SrcB;
      4'h4: fast_d = SrcA ^ SrcB;
      4'h5: fast_d = SrcA << sh;
      4'h6: fast_d = SrcA >> sh;
      4'h7: fast_d = $unsigned($signed(SrcA) >>> sh);
      4'h8: fast_d = W'($signed(SrcA) < $signed(SrcB));
      4'h9: fast_d = W'(SrcA < SrcB);
      4'hA: fast_d = SrcB;
      4'hD: fast_d = div0 ? '1 : SrcA;
      4'hE: fast_d = '1;
      4'hF: fast_d = SrcA;
      default: fast_d = '0;
    endcase
  end

  // acc_q holds the running product for MUL/MULHU, or {remainder, quotient} for divides
  assign sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff   = rem_sh - {1'b0, b_q};
  assign acc_d  = (op_q <= 4'hC) ? {sum, acc_q[W-1:1]} :
                  diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0} : {diff[W-1:0], acc_q[W-2:0], 1'b1};
  assign quo    = acc_d[W-1:0];
  assign slow_d = (op_q == 4'hB) ? quo :
                  (op_q == 4'hD) ? (neg_q ? -quo : quo) :
                  (op_q == 4'hE) ? quo : acc_d[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= op_in;
          eq_q <= SrcA == SrcB;
          if (iterate) begin
            state_q <= CALC;
            cnt_q   <= '0;
            acc_q   <= {{W{1'b0}}, (op_in == 4'hD) ? a_abs : SrcA};
            b_q     <= (op_in == 4'hD) ? b_abs : SrcB;
            neg_q   <= SrcA[W-1] ^ SrcB[W-1];
          end else begin
            state_q <= DONE;
            res_q   <= fast_d;
            zero_q  <= SrcA == SrcB;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            res_q   <= slow_d;
            zero_q  <= eq_q;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
